// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the fetch stage
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc8;
    } fetch_entry_t;

    function automatic word_t pc_plus8(input word_t pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small FIFO of fetched instructions with clear
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; count_q alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with prefetch queue and IF/ID register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCWrPendingF,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    word_t         pcf_q, pcf_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    word_t         id_instr_q, id_instr_d;
    word_t         id_pc8_q, id_pc8_d;
    logic          id_valid_q, id_valid_d;
    logic [PW-1:0] aptr_wr_q, aptr_wr_d;
    logic [PW-1:0] aptr_rd_q, aptr_rd_d;
    word_t         addr_q [DEPTH];

    logic          redirect, issue, rsp, rsp_keep, room;
    logic          load_id, bypass, q_push, q_pop;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [CW:0]   inflight;
    word_t         target;
    fetch_entry_t  rsp_entry, q_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect = PCSrcW | BranchTakenE;
    assign target   = PCSrcW ? ResultW : ALUResultE;

    // Outstanding requests plus queued entries never exceed DEPTH, so every
    // response always has a queue slot waiting for it.
    assign inflight = {1'b0, outstanding_q} + {1'b0, q_count};
    assign room     = ~q_full & (inflight < (CW + 1)'(DEPTH));
    assign ImemReq  = ~reset & ~StallF & ~PCWrPendingF & ~redirect & room;
    assign issue    = ImemReq & ImemAck;

    // Responses with nothing outstanding are stale (e.g. from before reset).
    assign rsp      = ImemRvalid & (outstanding_q != '0);
    assign rsp_keep = rsp & (discard_q == '0) & ~redirect;

    assign rsp_entry.instr = ImemRdata;
    assign rsp_entry.pc8   = pc_plus8(addr_q[aptr_rd_q]);

    assign load_id = ~redirect & ~FlushD & ~StallD;
    assign q_pop   = load_id & ~q_empty;
    assign bypass  = load_id & q_empty & rsp_keep;
    assign q_push  = rsp_keep & ~bypass;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (rsp_entry),
        .pop       (q_pop),
        .clear     (redirect),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_comb begin
        pcf_d = pcf_q;
        if (redirect)   pcf_d = target;
        else if (issue) pcf_d = pcf_q + 32'd4;

        outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);

        discard_d = discard_q;
        if (redirect)                       discard_d = outstanding_d;
        else if (rsp && discard_q != '0)    discard_d = discard_q - 1'b1;

        aptr_wr_d = issue ? ptr_inc(aptr_wr_q) : aptr_wr_q;
        aptr_rd_d = rsp   ? ptr_inc(aptr_rd_q) : aptr_rd_q;

        id_instr_d = id_instr_q;
        id_pc8_d   = id_pc8_q;
        id_valid_d = id_valid_q;
        if (redirect || FlushD) begin
            id_instr_d = '0;
            id_pc8_d   = '0;
            id_valid_d = 1'b0;
        end else if (!StallD) begin
            if (!q_empty) begin
                id_instr_d = q_head.instr;
                id_pc8_d   = q_head.pc8;
                id_valid_d = 1'b1;
            end else if (bypass) begin
                id_instr_d = rsp_entry.instr;
                id_pc8_d   = rsp_entry.pc8;
                id_valid_d = 1'b1;
            end else begin
                id_instr_d = '0;
                id_pc8_d   = '0;
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            aptr_wr_q     <= '0;
            aptr_rd_q     <= '0;
            id_instr_q    <= '0;
            id_pc8_q      <= '0;
            id_valid_q    <= 1'b0;
        end else begin
            pcf_q         <= pcf_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            aptr_wr_q     <= aptr_wr_d;
            aptr_rd_q     <= aptr_rd_d;
            id_instr_q    <= id_instr_d;
            id_pc8_q      <= id_pc8_d;
            id_valid_q    <= id_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) addr_q[aptr_wr_q] <= pcf_q;
    end

    assign ImemAddr = pcf_q;
    assign PCF      = pcf_q;
    assign InstrD   = id_instr_q;
    assign PCPlus8D = id_pc8_q;
    assign ValidD   = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with random imem latency
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCWrPendingF;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic        ImemReq, ImemAck, ImemRvalid;
    logic [31:0] ImemAddr, ImemRdata;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCWrPendingF (PCWrPendingF),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemRvalid   (ImemRvalid),
        .ImemRdata    (ImemRdata),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; int ready; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc8; } exp_t;
    pend_t       pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          lat_min = 1, lat_max = 1, rsp_pct = 100;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic idle();
        StallF = 0; StallD = 0; FlushD = 0; PCWrPendingF = 0;
        BranchTakenE = 0; PCSrcW = 0; ALUResultE = '0; ResultW = '0;
    endtask

    // Instruction memory: in-order responses, at least one cycle after issue.
    initial begin
        ImemRvalid = 0;
        ImemRdata  = '0;
        forever begin
            @(posedge clk); #1;
            ImemRvalid = 0;
            ImemRdata  = $urandom;
            if (pend_q.size() > 0 && pend_q[0].ready <= cyc + 1 &&
                $urandom_range(99) < rsp_pct) begin
                ImemRvalid = 1;
                ImemRdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
        end
    end

    // Program-order model: each accepted fetch becomes one expected delivery.
    always @(negedge clk) begin
        if (reset) begin
            model_pc = RESET_PC;
        end else begin
            chk("pcf", PCF, model_pc);
            if (StallF || PCWrPendingF || BranchTakenE || PCSrcW)
                chk("req_gated", 32'(ImemReq), 32'd0);
            if (ImemReq && ImemAck) begin
                chk("imem_addr", ImemAddr, model_pc);
                pend_q.push_back('{addr: ImemAddr,
                                   ready: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
                exp_q.push_back('{instr: mem_word(model_pc), pc8: model_pc + 32'd8});
                model_pc = model_pc + 32'd4;
            end
            if (PCSrcW)            model_pc = ResultW;
            else if (BranchTakenE) model_pc = ALUResultE;
            chk("inflight_bound", 32'(pend_q.size() <= DEPTH), 32'd1);
        end
    end

    // Monitor: IF/ID contents against the head of the expected stream.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_validd", 32'(ValidD), 32'd0);
            chk("rst_instrd", InstrD, 32'd0);
            chk("rst_pc8d", PCPlus8D, 32'd0);
            chk("rst_pcf", PCF, RESET_PC);
            chk("rst_req", 32'(ImemReq), 32'd0);
            exp_q.delete();
        end else begin
            if (ValidD) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got %h want none (cycle %0d)", InstrD, cyc);
                end else begin
                    chk("instr_d", InstrD, exp_q[0].instr);
                    chk("pc_plus8_d", PCPlus8D, exp_q[0].pc8);
                    if (PCSrcW || BranchTakenE || FlushD || !StallD) void'(exp_q.pop_front());
                end
            end else begin
                chk("bubble_instr", InstrD, 32'd0);
            end
            if (PCSrcW || BranchTakenE) exp_q.delete();
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        ImemAck = 0;
        reset   = 1;
        @(posedge clk); #1;
        reset  = 0;
        StallF = 1;
        for (int k = 0; k < 60 && pend_q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("reset_drain", 32'(pend_q.size()), 32'd0);
        @(posedge clk); #1;
        StallF = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int issues;
        logic [31:0] held;

        idle();
        reset   = 1;
        ImemAck = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Memory not accepting: PCF parked, request held.
        repeat (3) begin
            @(negedge clk);
            chk("noack_req", 32'(ImemReq), 32'd1);
            chk("noack_pcf", PCF, RESET_PC);
            chk("noack_validd", 32'(ValidD), 32'd0);
        end

        // Single-cycle memory: first valid instruction two edges after first issue.
        @(posedge clk); #1;
        ImemAck = 1;
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ValidD) break;
        end
        chk("first_valid_latency", 32'(cyc - t0), 32'd2);
        repeat (8) @(posedge clk);

        // Decode stall: IF/ID holds, fetch stops after the window fills.
        do_reset();
        lat_min = 1; lat_max = 1; ImemAck = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ValidD) break;
        end
        @(posedge clk); #1;
        StallD = 1;
        issues = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) held = InstrD;
            else chk("stall_hold", InstrD, held);
            if (ImemReq && ImemAck) issues++;
        end
        chk("stall_req_off", 32'(ImemReq), 32'd0);
        chk("stall_issue_cap", 32'(issues <= DEPTH), 32'd1);
        @(posedge clk); #1;
        StallD = 0;
        repeat (8) @(posedge clk);

        // Branch with two requests in flight: both responses must be dropped.
        do_reset();
        lat_min = 4; lat_max = 4; ImemAck = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pend_q.size() == 2) break;
        end
        chk("two_in_flight", 32'(pend_q.size()), 32'd2);
        @(posedge clk); #1;
        BranchTakenE = 1; ALUResultE = 32'h0000_0100;
        @(posedge clk); #1;
        BranchTakenE = 0;
        @(negedge clk);
        chk("branch_pcf", PCF, 32'h0000_0100);
        chk("branch_addr", ImemAddr, 32'h0000_0100);
        chk("branch_bubble", 32'(ValidD), 32'd0);
        repeat (15) @(posedge clk);

        // PC write from W outranks the branch from E.
        @(posedge clk); #1;
        PCSrcW = 1; ResultW = 32'h0000_0200;
        BranchTakenE = 1; ALUResultE = 32'h0000_0100;
        @(posedge clk); #1;
        PCSrcW = 0; BranchTakenE = 0;
        @(negedge clk);
        chk("pcsrcw_priority", PCF, 32'h0000_0200);
        repeat (10) @(posedge clk);

        // Reset with one request outstanding; its late response must vanish.
        lat_min = 5; lat_max = 5;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ImemReq && ImemAck) break;
        end
        @(posedge clk); #1;
        ImemAck = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0; StallF = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("late_rsp_dropped", 32'(ValidD), 32'd0);
        end
        chk("late_rsp_consumed", 32'(pend_q.size()), 32'd0);
        @(posedge clk); #1;
        StallF = 0; ImemAck = 1; lat_min = 1; lat_max = 2;
        @(negedge clk);
        chk("post_reset_addr", ImemAddr, RESET_PC);
        chk("post_reset_req", 32'(ImemReq), 32'd1);
        repeat (10) @(posedge clk);

        // PCPlus8D and PCF wrap modulo 2^32.
        @(posedge clk); #1;
        BranchTakenE = 1; ALUResultE = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        BranchTakenE = 0;
        repeat (12) @(posedge clk);

        // Randomized hazards, redirects and memory timing.
        lat_min = 1; lat_max = 4; rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            StallF       = ($urandom_range(99) < 15);
            StallD       = ($urandom_range(99) < 20);
            FlushD       = ($urandom_range(99) < 5);
            PCWrPendingF = ($urandom_range(99) < 5);
            BranchTakenE = ($urandom_range(99) < 4);
            PCSrcW       = ($urandom_range(99) < 3);
            ALUResultE   = $urandom & 32'hFFFF_FFFC;
            ResultW      = $urandom & 32'hFFFF_FFFC;
            ImemAck      = ($urandom_range(99) < 70);
        end

        // Drain: every fetched instruction must have been delivered.
        @(posedge clk); #1;
        idle();
        StallF = 1; ImemAck = 0; rsp_pct = 100;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_expected_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_pending_empty", 32'(pend_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
